lcd_bus_decoder: RTL

- Listening end of the 4-bit HD44780-style LCD bus that LCD_module drives (LCD_E, LCD_RS, LCD_RW, LCD_D).
- Reassembles nibbles into bytes, executes the command subset LCD_module uses, and maintains a 2x16 character shadow of the display.
- Presents the shadow as row_A/row_B in the same 128-bit packing the top level feeds LCD_module. This gives closed-loop checking in simulation and on-board readback of scrolling text.

---
 rtl/lcd_bus_decoder_pkg.sv | 35 +++
 rtl/lcd_bus_decoder_if.sv | 10 +
 rtl/lcd_bus_decoder_strobe_sync.sv | 38 +++
 rtl/lcd_bus_decoder.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/lcd_bus_decoder_pkg.sv
// Shared types and constants for the HD44780-style LCD bus listener.
// Used by lcd_bus_decoder and lcd_strobe_sync via import lcd_dec_pkg::*.
package lcd_dec_pkg;

  // Nibble-assembly phase of the 4-bit bus.
  typedef enum logic [1:0] {
    MODE8 = 2'd0,
    HI    = 2'd1,
    LO    = 2'd2
  } mode_e;

  // Which RAM receives data writes.
  typedef enum logic {
    TGT_DDRAM = 1'b0,
    TGT_CGRAM = 1'b1
  } target_e;

  // Command opcodes; for a command byte, the highest set bit selects the command.
  localparam logic [7:0] CMD_CLR   = 8'h01;
  localparam logic [7:0] CMD_HOME  = 8'h02;
  localparam logic [7:0] CMD_ENTRY = 8'h04;
  localparam logic [7:0] CMD_DISP  = 8'h08;
  localparam logic [7:0] CMD_FUNC  = 8'h20;
  localparam logic [7:0] CMD_CGRAM = 8'h40;
  localparam logic [7:0] CMD_DDRAM = 8'h80;

  localparam logic [7:0] CHAR_SPACE = 8'h20;

  // DDRAM layout of the two visible rows.
  localparam logic [6:0] ROW_A_BASE = 7'h00;
  localparam logic [6:0] ROW_B_BASE = 7'h40;
  localparam int         ROW_LEN    = 16;
  localparam logic [6:0] FRAME_ADDR = ROW_B_BASE + 7'(ROW_LEN - 1);

endpackage

// File: rtl/lcd_bus_decoder_if.sv
// LCD bus bundle: LCD_module drives it (master), the decoder listens (slave).
interface lcd_bus_if;
  logic       LCD_E;
  logic       LCD_RS;
  logic       LCD_RW;
  logic [3:0] LCD_D;

  modport master (output LCD_E, LCD_RS, LCD_RW, LCD_D);
  modport slave  (input  LCD_E, LCD_RS, LCD_RW, LCD_D);
endinterface

// File: rtl/lcd_bus_decoder_strobe_sync.sv
// Synchronizes the asynchronous LCD bus into clk and flags falling edges of E.
// RS/RW/D are taken from the same synced stage as E so that they stay coherent.
module lcd_strobe_sync
  import lcd_dec_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  lcd_bus_if.slave   bus,
  output logic       strobe,
  output logic       rs,
  output logic       rw,
  output logic [3:0] nib
);

  // Stage layout per word: {E, RS, RW, D[3:0]}.
  logic [SYNC_STAGES-1:0][6:0] sync_q;
  logic                        e_prev;

  // Shift the whole bus through the synchronizer chain and remember the last synced E.
  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      e_prev <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], {bus.LCD_E, bus.LCD_RS, bus.LCD_RW, bus.LCD_D}};
      e_prev <= sync_q[SYNC_STAGES-1][6];
    end
  end

  assign strobe = e_prev & ~sync_q[SYNC_STAGES-1][6];
  assign rs     = sync_q[SYNC_STAGES-1][5];
  assign rw     = sync_q[SYNC_STAGES-1][4];
  assign nib    = sync_q[SYNC_STAGES-1][3:0];

endmodule

// File: rtl/lcd_bus_decoder.sv
// Listening end of the 4-bit HD44780-style LCD bus: rebuilds bytes, runs the
// command subset LCD_module uses and keeps a 2x16 character shadow.
// Optional: define LCD_DEC_BUSY_CHECK_EN to build the bus-timing checker.
module lcd_bus_decoder
  import lcd_dec_pkg::*;
#(
  parameter int SYNC_STAGES = 2
`ifdef LCD_DEC_BUSY_CHECK_EN
  ,
  parameter int MIN_GAP_CYC = 4000,
  parameter int CLR_GAP_CYC = 164000
`endif
) (
  input  logic         clk,
  input  logic         reset_n,
  lcd_bus_if.slave     bus,
  output logic [127:0] row_A,
  output logic [127:0] row_B,
  output logic         wr_strobe,
  output logic [7:0]   byte_out,
  output logic         byte_rs,
  output logic         frame_done,
  output logic         timing_err
);

  logic       strobe, s_rs, s_rw;
  logic [3:0] s_nib;

  lcd_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .strobe  (strobe),
    .rs      (s_rs),
    .rw      (s_rw),
    .nib     (s_nib)
  );

  logic       pend_valid, pend_rs;
  logic [3:0] pend_nib;
  mode_e      mode;
  target_e    target;
  logic [3:0] hi_nib;
  logic [6:0] addr;
  logic       inc;
  logic [7:0] cells_a [ROW_LEN];
  logic [7:0] cells_b [ROW_LEN];

  logic       exec, do_clear, ddram_wr, wr_a, wr_b;
  logic [7:0] exec_byte;

  assign exec      = pend_valid && (mode == LO);
  assign exec_byte = {hi_nib, pend_nib};
  assign do_clear  = exec && !pend_rs && (exec_byte == CMD_CLR);
  assign ddram_wr  = exec && pend_rs && (target == TGT_DDRAM);
  assign wr_a      = ddram_wr && (addr[6:4] == ROW_A_BASE[6:4]);
  assign wr_b      = ddram_wr && (addr[6:4] == ROW_B_BASE[6:4]);

  // One-deep strobe flag: a write strobe is held for the following cycle, so a
  // strobe that lands while the previous nibble executes is never dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_valid <= 1'b0;
      pend_rs    <= 1'b0;
      pend_nib   <= '0;
    end else begin
      pend_valid <= strobe && !s_rw;
      pend_rs    <= s_rs;
      pend_nib   <= s_nib;
    end
  end

  // Nibble phase, address/entry state and the per-byte output pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode       <= MODE8;
      target     <= TGT_DDRAM;
      hi_nib     <= '0;
      addr       <= '0;
      inc        <= 1'b1;
      wr_strobe  <= 1'b0;
      byte_out   <= '0;
      byte_rs    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      wr_strobe  <= 1'b0;
      frame_done <= 1'b0;
      if (pend_valid) begin
        case (mode)
          MODE8: if (!pend_rs && pend_nib == CMD_FUNC[7:4]) mode <= HI;
          HI: begin
            hi_nib <= pend_nib;
            mode   <= LO;
          end
          LO: begin
            mode      <= HI;
            wr_strobe <= 1'b1;
            byte_out  <= exec_byte;
            byte_rs   <= pend_rs;
            if (pend_rs) begin
              if (target == TGT_DDRAM) begin
                frame_done <= (addr == FRAME_ADDR);
                addr       <= inc ? addr + 7'd1 : addr - 7'd1;
              end
            end else if (|(exec_byte & CMD_DDRAM)) begin
              target <= TGT_DDRAM;
              addr   <= exec_byte[6:0];
            end else if (|(exec_byte & CMD_CGRAM)) begin
              target <= TGT_CGRAM;
            end else if (|(exec_byte & CMD_FUNC)) begin
              if (exec_byte[4]) mode <= MODE8;
            end else if (|(exec_byte & (CMD_DISP | 8'h10))) begin
              // Display control and cursor/display shift do not touch the shadow.
            end else if (|(exec_byte & CMD_ENTRY)) begin
              inc <= exec_byte[1];
            end else if (|(exec_byte & CMD_HOME)) begin
              addr <= '0;
            end else if (exec_byte == CMD_CLR) begin
              addr <= '0;
              inc  <= 1'b1;
            end
          end
          default: mode <= MODE8;
        endcase
      end
    end
  end

  // Character shadow: clear fills both rows with spaces, DDRAM data lands in its cell.
  // NOTE: the shadow must read as spaces straight out of reset, so it lives in resettable flops, not RAM.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < ROW_LEN; i++) begin
        cells_a[i] <= CHAR_SPACE;
        cells_b[i] <= CHAR_SPACE;
      end
    end else if (do_clear) begin
      for (int i = 0; i < ROW_LEN; i++) begin
        cells_a[i] <= CHAR_SPACE;
        cells_b[i] <= CHAR_SPACE;
      end
    end else if (wr_a) begin
      cells_a[addr[3:0]] <= exec_byte;
    end else if (wr_b) begin
      cells_b[addr[3:0]] <= exec_byte;
    end
  end

  // Pack the rows with character 0 in the most significant byte.
  // NOTE: outputs get a full default first so no path through this block can infer a latch.
  always_comb begin
    row_A = '0;
    row_B = '0;
    for (int i = 0; i < ROW_LEN; i++) begin
      row_A[127-8*i -: 8] = cells_a[i];
      row_B[127-8*i -: 8] = cells_b[i];
    end
  end

`ifdef LCD_DEC_BUSY_CHECK_EN
  localparam int GAP_W = $clog2(CLR_GAP_CYC + 1);

  logic [GAP_W-1:0] gap_cnt;
  logic             last_slow;

  // Saturating gap counter between executions; early executions set the sticky error.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gap_cnt    <= GAP_W'(CLR_GAP_CYC);
      last_slow  <= 1'b0;
      timing_err <= 1'b0;
    end else if (exec) begin
      if (gap_cnt < GAP_W'(MIN_GAP_CYC) || (last_slow && gap_cnt < GAP_W'(CLR_GAP_CYC)))
        timing_err <= 1'b1;
      gap_cnt   <= '0;
      last_slow <= !pend_rs && (exec_byte == CMD_CLR || exec_byte[7:1] == CMD_HOME[7:1]);
    end else if (gap_cnt != GAP_W'(CLR_GAP_CYC)) begin
      gap_cnt <= gap_cnt + 1'b1;
    end
  end
`else
  assign timing_err = 1'b0;
`endif

endmodule
